generation_controller: RTL and testbench



---
 rtl/system_pkg.sv | 12 +
 rtl/generation_controller.sv | 114 +++++++++++
 tb/tb_generation_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/system_pkg.sv
// Shared types for the Conway system: controller state encoding used by the
// generation controller, the system top level and benches that probe state.
package system_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    RUN_WAIT   = 2'd2,
    RUN_COMMIT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/generation_controller.sv
// Sequences system memory writes: external pattern load, or one calculator
// result committed per generation once the calculator has settled.
module generation_controller
  import system_pkg::*;
#(
  parameter int CALC_LATENCY = 2,
  parameter int GEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic                 load_last,
  output logic                 load_ready,
  input  logic                 run_start,
  input  logic                 run_step,
  input  logic                 run_stop,
  input  logic [GEN_WIDTH-1:0] gen_limit,
  output logic                 write_enable,
  output logic                 load_run,
  output logic                 busy,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic                 done
);

  localparam int CW = (CALC_LATENCY < 1) ? 1 : $clog2(CALC_LATENCY + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(CALC_LATENCY - 1);

  ctrl_state_e          state_q, state_d;
  logic [CW-1:0]        settle_q, settle_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic [GEN_WIDTH-1:0] run_q, run_d;
  logic                 step_q, step_d;
  logic                 done_q, done_d;
  logic [GEN_WIDTH-1:0] run_inc;

  assign run_inc = run_q + GEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      gen_q    <= '0;
      run_q    <= '0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gen_q    <= gen_d;
      run_q    <= run_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gen_d    = gen_q;
    run_d    = run_q;
    step_d   = step_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          gen_d   = '0;
        end else if (run_start || run_step) begin
          state_d  = RUN_WAIT;
          settle_d = '0;
          run_d    = '0;
          step_d   = run_step & ~run_start;
        end
      end
      LOAD: begin
        if (load_valid && load_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      RUN_WAIT: begin
        settle_d = settle_q + CW'(1);
        // Stop wins over the settle-complete transition: nothing is committed.
        if (run_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = RUN_COMMIT;
        end
      end
      RUN_COMMIT: begin
        gen_d = gen_q + GEN_WIDTH'(1);
        run_d = run_inc;
        if (step_q || run_stop || ((gen_limit != '0) && (run_inc == gen_limit))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d  = RUN_WAIT;
          settle_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign write_enable = (state_q == RUN_COMMIT) || ((state_q == LOAD) && load_valid);
  assign load_run     = (state_q == RUN_WAIT) || (state_q == RUN_COMMIT);
  assign load_ready   = (state_q == LOAD);
  assign busy         = (state_q != IDLE);
  assign gen_count    = gen_q;
  assign done         = done_q;

endmodule

// File: tb/tb_generation_controller.sv
// Bench for generation_controller: schedule-based reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_generation_controller;
  import system_pkg::*;

  localparam int CL = 2;
  localparam int GW = 8;
  localparam int P  = CL + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic          run_start = 1'b0, run_step = 1'b0, run_stop = 1'b0;
  logic [GW-1:0] gen_limit = '0;
  logic          load_ready, write_enable, load_run, busy, done;
  logic [GW-1:0] gen_count;

  generation_controller #(.CALC_LATENCY(CL), .GEN_WIDTH(GW)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_ready(load_ready),
    .run_start(run_start), .run_step(run_step), .run_stop(run_stop),
    .gen_limit(gen_limit),
    .write_enable(write_enable), .load_run(load_run), .busy(busy),
    .gen_count(gen_count), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 loading, 2 running. A run's commits fall on
  // every P-th cycle, CL cycles after the first post-start cycle t0.
  int            m_mode = 0;
  int            m_cyc = 0;
  int            m_t0 = 0;
  int            m_run = 0;
  bit            m_step = 0;
  bit            m_done = 0;
  bit            m_armed = 0;
  logic [GW-1:0] m_gen = '0;
  bit            m_commit;

  function automatic bit commit_at(input int c);
    return (m_mode == 2) && (c >= m_t0) && (((c - m_t0) % P) == CL);
  endfunction

  always @(posedge clk) begin
    m_commit = commit_at(m_cyc);
    m_done = 0;
    if (reset) begin
      m_mode = 0; m_gen = '0; m_run = 0; m_step = 0; m_armed = 1;
    end else begin
      case (m_mode)
        0: if (load_start) begin
             m_mode = 1; m_gen = '0;
           end else if (run_start || run_step) begin
             m_mode = 2; m_t0 = m_cyc + 1; m_run = 0; m_step = run_step && !run_start;
           end
        1: if (load_valid && load_last) begin m_mode = 0; m_done = 1; end
        default: begin
          if (m_commit) begin
            m_gen = m_gen + 1'b1;
            m_run = m_run + 1;
            if (m_step || run_stop || (gen_limit != 0 && m_run == int'(gen_limit))) begin
              m_mode = 0; m_done = 1;
            end
          end else if (run_stop) begin
            m_mode = 0; m_done = 1;
          end
        end
      endcase
    end
    m_cyc++;
  end

  int we_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (m_armed) begin
      chk("write_enable", write_enable,
          (m_mode == 1 && load_valid) || commit_at(m_cyc));
      chk("load_run", load_run, m_mode == 2);
      chk("load_ready", load_ready, m_mode == 1);
      chk("busy", busy, m_mode != 0);
      chk("done", done, m_done);
      chk("gen_count", gen_count, m_gen);
      if (write_enable === 1'b1) we_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin tick(); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_load(input int words);
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < words; i++) begin
      load_valid = 1'b1; load_last = (i == words - 1); tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic do_step();
    run_step = 1'b1; tick(); run_step = 1'b0;
    ticks(3);
  endtask

  int we0, dn0;

  initial begin
    // Reset
    ticks(2);
    reset = 1'b0;
    chk("rst_state", dut.state_q == IDLE, 1'b1);
    chk("rst_gen", gen_count, 0);
    tick();

    // Load three words
    we0 = we_cnt; dn0 = done_cnt;
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("load_ready_lit", load_ready, 1'b1);
    do_load(0);
    load_valid = 1'b1; tick(); tick(); load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("load_done_lit", done, 1'b1);
    ticks(2);
    chk("load_we_count", we_cnt - we0, 3);
    chk("load_done_count", done_cnt - dn0, 1);
    chk("load_gen_lit", gen_count, 0);

    // Single step twice; commit lands in the 3rd cycle after run_step
    run_step = 1'b1; tick(); run_step = 1'b0;
    tick(); tick();
    chk("step_commit_cycle", write_enable, 1'b1);
    tick();
    chk("step1_gen", gen_count, 1);
    chk("step1_done", done, 1'b1);
    ticks(3);
    do_step();
    chk("step2_gen", gen_count, 2);

    // Priority: load_start beats run_start; then clear with a one-word load
    load_start = 1'b1; run_start = 1'b1; tick(); load_start = 1'b0; run_start = 1'b0;
    chk("prio_load_ready", load_ready, 1'b1);
    chk("prio_load_run", load_run, 1'b0);
    load_valid = 1'b1; load_last = 1'b1; tick(); load_valid = 1'b0; load_last = 1'b0;
    chk("prio_gen", gen_count, 0);
    tick();

    // Limited run: 4 generations
    we0 = we_cnt; dn0 = done_cnt;
    gen_limit = 8'd4;
    run_start = 1'b1; tick(); run_start = 1'b0;
    wait_idle(40);
    tick();
    chk("limit_we_count", we_cnt - we0, 4);
    chk("limit_gen", gen_count, 4);
    chk("limit_done_count", done_cnt - dn0, 1);

    // Stop during RUN_WAIT: no commit
    gen_limit = 8'd0;
    we0 = we_cnt;
    run_start = 1'b1; tick(); run_start = 1'b0;
    run_stop = 1'b1; tick(); run_stop = 1'b0;
    chk("stopw_idle", busy, 1'b0);
    ticks(4);
    chk("stopw_we_count", we_cnt - we0, 0);
    chk("stopw_gen", gen_count, 4);

    // Stop during second RUN_COMMIT: that commit still happens
    run_start = 1'b1; tick(); run_start = 1'b0;
    ticks(5);
    chk("stopc_in_commit", write_enable, 1'b1);
    run_stop = 1'b1; tick(); run_stop = 1'b0;
    chk("stopc_idle", busy, 1'b0);
    chk("stopc_gen", gen_count, 6);
    tick();

    // Wrap: 255 steps from a fresh load, then one more
    do_load(1);
    for (int i = 0; i < 255; i++) do_step();
    chk("wrap_255", gen_count, 255);
    do_step();
    chk("wrap_0", gen_count, 0);

    // Reset in RUN_COMMIT
    run_start = 1'b1; tick(); run_start = 1'b0;
    tick(); tick();
    chk("rstc_in_commit", write_enable, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstc_state", dut.state_q == IDLE, 1'b1);
    chk("rstc_we", write_enable, 1'b0);
    chk("rstc_load_run", load_run, 1'b0);
    we0 = we_cnt;
    ticks(4);
    chk("rstc_no_we", we_cnt - we0, 0);

    // Reset in LOAD mid-stream, load_valid still high
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstl_state", dut.state_q == IDLE, 1'b1);
    chk("rstl_we", write_enable, 1'b0);
    chk("rstl_ready", load_ready, 1'b0);
    load_valid = 1'b0;
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
